// File: rtl/instr_fetch_if.sv
// instr_fetch_if: loader, run-control and fetch signals between the host/CPU and instr_fetch
interface instr_fetch_if #(parameter int PCW = 8);
  logic           loadstart;
  logic           loadvalid;
  logic [7:0]     loaddata;
  logic           loaddone;
  logic           start;
  logic           stall;
  logic           branch;
  logic           zero;
  logic [7:0]     instruction;
  logic [PCW-1:0] pc;
  logic           running;
  logic           halted;
  logic           loading;
  modport master (
    output loadstart, loadvalid, loaddata, loaddone, start, stall, branch, zero,
    input  instruction, pc, running, halted, loading
  );
  modport slave (
    input  loadstart, loadvalid, loaddata, loaddone, start, stall, branch, zero,
    output instruction, pc, running, halted, loading
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: program ROM with byte-stream loader, program counter and IDLE/LOAD/RUN/HALT sequencer
module instr_fetch #(
  parameter int         PCW      = 8,
  parameter logic [7:0] HALTWORD = 8'hFF
) (
  input logic         clk,
  input logic         resetn,
  instr_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
  state_t         state, state_n;
  logic [PCW-1:0] pc, pc_n, ptr, ptr_n;
  logic [7:0]     mem [2**PCW];
  logic [7:0]     fetched;
  logic           we;
  logic           last;
  assign fetched = mem[pc];
  assign last    = &ptr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      pc    <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ptr   <= ptr_n;
    end
  // program memory is deliberately outside reset so a program survives resetn
  always_ff @(posedge clk)
    if (we) mem[ptr] <= bus.loaddata;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ptr_n   = ptr;
    we      = 1'b0;
    unique case (state)
      IDLE, HALT:
        if (bus.loadstart) begin
          state_n = LOAD;
          ptr_n   = '0;
        end else if (bus.start) begin
          state_n = RUN;
          pc_n    = '0;
        end
      LOAD: begin
        we = bus.loadvalid;
        if (we && !last) ptr_n = ptr + PCW'(1);
        if ((we && last) || bus.loaddone) state_n = IDLE;
      end
      RUN:
        if (fetched == HALTWORD) state_n = HALT;
        else if (!bus.stall)
          pc_n = pc + PCW'(1) + ((bus.branch && bus.zero) ? {{(PCW-2){fetched[1]}}, fetched[1:0]} : '0);
      default: ;
    endcase
  end
  assign bus.pc          = pc;
  assign bus.running     = state == RUN;
  assign bus.halted      = state == HALT;
  assign bus.loading     = state == LOAD;
  assign bus.instruction = (state == RUN) ? fetched : 8'h00;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed plan plus randomized traffic, checked every cycle against a behavioural model
module tb_instr_fetch;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  instr_fetch_if #(.PCW(8)) bus();
  instr_fetch #(.PCW(8), .HALTWORD(8'hFF)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  int          n_chk = 0;
  int          n_pass = 0;
  byte unsigned mem_m [256];
  int          m_pc = 0;
  int          m_ptr = 0;
  string       m_mode = "IDLE";
  logic [7:0]  q [$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  task automatic compare_all();
    check("pc", 32'(bus.pc), 32'(m_pc));
    check("instruction", 32'(bus.instruction), (m_mode == "RUN") ? 32'(mem_m[m_pc]) : 32'd0);
    check("running", 32'(bus.running), 32'(m_mode == "RUN"));
    check("halted", 32'(bus.halted), 32'(m_mode == "HALT"));
    check("loading", 32'(bus.loading), 32'(m_mode == "LOAD"));
  endtask
  task automatic model_step();
    int v, off;
    if (!resetn) return;
    if (m_mode == "IDLE" || m_mode == "HALT") begin
      if (bus.loadstart) begin m_mode = "LOAD"; m_ptr = 0; end
      else if (bus.start) begin m_mode = "RUN"; m_pc = 0; end
    end else if (m_mode == "LOAD") begin
      if (bus.loadvalid) begin
        mem_m[m_ptr] = bus.loaddata;
        if (m_ptr == 255) m_mode = "IDLE";
        else m_ptr++;
      end
      if (bus.loaddone) m_mode = "IDLE";
    end else begin
      v   = mem_m[m_pc] % 4;
      off = (v > 1) ? v - 4 : v;
      if (mem_m[m_pc] == 255) m_mode = "HALT";
      else if (!bus.stall) m_pc = (m_pc + 1 + ((bus.branch && bus.zero) ? off : 0) + 256) % 256;
    end
  endtask
  // inputs change just after the rising edge; outputs are compared on the falling edge
  task automatic tick();
    @(negedge clk);
    if (!resetn) begin m_mode = "IDLE"; m_pc = 0; m_ptr = 0; end
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.loadstart = 1'b0;
    bus.loadvalid = 1'b0;
    bus.loaddata  = 8'h00;
    bus.loaddone  = 1'b0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    bus.branch    = 1'b0;
    bus.zero      = 1'b0;
  endtask
  task automatic load(input logic [7:0] b [$], input bit done_on_last);
    bus.loadstart = 1'b1;
    tick();
    bus.loadstart = 1'b0;
    foreach (b[i]) begin
      bus.loadvalid = 1'b1;
      bus.loaddata  = b[i];
      bus.loaddone  = done_on_last && (i == b.size() - 1);
      tick();
    end
    bus.loadvalid = 1'b0;
    bus.loaddone  = 1'b0;
  endtask
  task automatic run_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic async_reset();
    #2 resetn = 1'b0;
    #1;
    check("rst_now_pc", 32'(bus.pc), 32'd0);
    check("rst_now_running", 32'(bus.running), 32'd0);
    check("rst_now_instr", 32'(bus.instruction), 32'd0);
    tick();
    resetn = 1'b1;
  endtask
  initial begin
    idle_inputs();
    #3;
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_instr", 32'(bus.instruction), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_loading", 32'(bus.loading), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    q = {};
    for (int i = 0; i < 256; i++) q.push_back((i == 0) ? 8'h02 : 8'($urandom_range(0, 254)));
    load(q, 1'b0);
    check("auto_exit_loading", 32'(bus.loading), 32'd0);
    run_start();
    check("start_pc", 32'(bus.pc), 32'd0);
    check("start_running", 32'(bus.running), 32'd1);
    repeat (255) tick();
    check("pc_ff", 32'(bus.pc), 32'hFF);
    tick();
    check("wrap_up", 32'(bus.pc), 32'h00);
    bus.branch = 1'b1;
    bus.zero   = 1'b1;
    tick();
    check("wrap_down", 32'(bus.pc), 32'hFF);
    idle_inputs();
    bus.loadstart = 1'b1;
    tick();
    bus.loadstart = 1'b0;
    check("loadstart_in_run", 32'(bus.running), 32'd1);
    async_reset();
    bus.loadstart = 1'b1;
    bus.start     = 1'b1;
    tick();
    idle_inputs();
    check("loadstart_wins", 32'(bus.loading), 32'd1);
    q = '{8'h12, 8'h45, 8'h8A, 8'hFF};
    foreach (q[i]) begin
      bus.loadvalid = 1'b1;
      bus.loaddata  = q[i];
      bus.start     = (i == 0);
      bus.loaddone  = (i == 3);
      tick();
      if (i == 0) check("start_in_load", 32'(bus.loading), 32'd1);
    end
    idle_inputs();
    check("done_with_valid", 32'(bus.loading), 32'd0);
    run_start();
    for (int k = 0; k < 4; k++) begin
      check("seq_pc", 32'(bus.pc), 32'(k));
      check("seq_instr", 32'(bus.instruction), 32'(q[k]));
      check("seq_opcode", 32'(bus.instruction[7:6]), 32'(k));
      tick();
    end
    check("halt_flag", 32'(bus.halted), 32'd1);
    check("halt_pc", 32'(bus.pc), 32'd3);
    run_start();
    check("rerun_instr", 32'(bus.instruction), 32'h12);
    repeat (4) tick();
    load('{8'h00, 8'h00, 8'hC2, 8'h00, 8'h00, 8'hC2, 8'h00, 8'hFF}, 1'b1);
    run_start();
    repeat (2) tick();
    bus.stall  = 1'b1;
    bus.branch = 1'b1;
    bus.zero   = 1'b1;
    repeat (3) begin
      tick();
      check("stall_pc", 32'(bus.pc), 32'd2);
      check("stall_instr", 32'(bus.instruction), 32'hC2);
    end
    idle_inputs();
    repeat (3) tick();
    check("br_at5", 32'(bus.pc), 32'd5);
    bus.branch = 1'b1;
    bus.zero   = 1'b1;
    tick();
    check("br_taken_m2", 32'(bus.pc), 32'd4);
    idle_inputs();
    tick();
    bus.branch = 1'b1;
    tick();
    check("br_not_taken", 32'(bus.pc), 32'd6);
    idle_inputs();
    repeat (2) tick();
    check("br_prog_halt", 32'(bus.halted), 32'd1);
    load('{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC1, 8'h00, 8'hFF}, 1'b1);
    run_start();
    repeat (3) tick();
    check("pre_reset_pc", 32'(bus.pc), 32'd3);
    async_reset();
    run_start();
    check("retained_instr", 32'(bus.instruction), 32'h40);
    repeat (5) tick();
    bus.branch = 1'b1;
    bus.zero   = 1'b1;
    tick();
    check("br_taken_p1", 32'(bus.pc), 32'd7);
    idle_inputs();
    tick();
    repeat (3000) begin
      resetn        = ($urandom_range(0, 199) != 0);
      bus.loadstart = ($urandom_range(0, 29) == 0);
      bus.start     = ($urandom_range(0, 19) == 0);
      bus.loadvalid = 1'($urandom_range(0, 1));
      bus.loaddata  = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
      bus.loaddone  = ($urandom_range(0, 24) == 0);
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.branch    = ($urandom_range(0, 2) == 0);
      bus.zero      = 1'($urandom_range(0, 1));
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and program-load unit for the 8-bit single-cycle CPU. It holds the program ROM, the program counter and the run/halt sequencer. It is the source of `instruction[7:0]`, and `control` decodes `instruction[7:6]` into its datapath strobes. It consumes `control`'s `branch` strobe and the ALU `zero` flag to compute the next PC. A byte-stream loader port fills the program memory before execution.

## Interface
- `PCW`, 8: PC and memory address width; memory depth is 2^PCW bytes.
- `HALTWORD`, 8'hFF: an instruction equal to this value stops execution.

- `clk`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous, active-low reset
- `loadstart`  in  1  one-cycle pulse: enter LOAD, write pointer := 0
- `loadvalid`  in  1  `loaddata` valid this cycle
- `loaddata`  in  8  program byte
- `loaddone`  in  1  one-cycle pulse: leave LOAD
- `start`  in  1  one-cycle pulse: begin execution at PC 0
- `stall`  in  1  hold PC and instruction this cycle
- `branch`  in  1  from `control`
- `zero`  in  1  from ALU
- `instruction`  out  8  current instruction, to `control`/register file
- `pc`  out  PCW  current program counter
- `running`  out  1  high in RUN; `instruction` is meaningful only when high
- `halted`  out  1  high in HALT
- `loading`  out  1  high in LOAD

## Operation
- States: IDLE, LOAD, RUN, HALT. Reset → IDLE.
- IDLE/HALT + `loadstart` → LOAD, write pointer := 0. If `start` is asserted in the same cycle, `loadstart` wins.
- IDLE/HALT + `start` → RUN, `pc` := 0.
- LOAD: each `loadvalid` cycle writes mem[ptr] := `loaddata`, then ptr += 1.
  - A write at ptr = 2^PCW−1 → IDLE, with no wrap.
  - `loaddone` → IDLE. A `loadvalid` in the same cycle is still written first.
  - `start` and `loadstart` are ignored in LOAD.
- RUN: `instruction` = mem[`pc`], combinational read.
  - Each cycle with `stall` = 0 updates the PC:
    - `branch` & `zero` → `pc` := `pc` + 1 + sext(`instruction[1:0]`), with a 2-bit signed offset in the range −2..+1.
    - Otherwise `pc` := `pc` + 1.
  - All PC arithmetic is modulo 2^PCW, so 8'hFF + 1 wraps to 0.
  - `stall` = 1: `pc` holds; branch inputs are ignored.
  - `instruction` == HALTWORD → HALT on the next edge, `pc` holds at the halt address, regardless of `stall`/`branch`.
  - `start`, `loadstart`, `loaddone` and `loadvalid` are ignored in RUN.
- HALT: `pc` holds; memory retains its contents, so a new `start` re-runs the program without reloading.
- Outside RUN: `instruction` = 8'h00.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - `pc` = 0, `instruction` = 8'h00
  - `running` = 0, `halted` = 0, `loading` = 0
  - write pointer = 0, state IDLE
- `resetn` low mid-LOAD or mid-RUN: all of the above take effect immediately (asynchronous). Bytes already written remain.
- `start` sampled at edge N: `running` = 1 and `pc` = 0 after edge N. `instruction` = mem[0] in cycle N+1.
- The PC update is visible one edge after the `branch`/`zero` sample, giving a single-cycle CPU with no delay slot.
- HALTWORD fetched in cycle K: `running` = 0 and `halted` = 1 after edge K.
- A load write at edge N can be read in RUN from the following cycle.
- `loading` rises the edge after `loadstart` and falls the edge after `loaddone` or after the final-address write.

## Test plan
- **Reset and load.** Stimulus: reset, then `loadstart`, then write bytes 8'h12, 8'h45, 8'h8A, 8'hFF, then `loaddone`, then `start`. Required: `pc` steps 0,1,2,3; `instruction` steps 12,45,8A,FF; `halted` = 1 with `pc` = 3; `instruction[7:6]` to `control` = 0,1,2,3.
- **Branch taken and not taken.** Stimulus: at `pc` = 5, `instruction` = 8'hC2 (offset −2). Required: `branch` = 1, `zero` = 1 → `pc` = 4. `branch` = 1, `zero` = 0 → `pc` = 6. Offset 8'hC1 with `zero` = 1 → `pc` = 7.
- **Stall.** Stimulus: hold `stall` for 3 cycles at `pc` = 2 while `branch` & `zero` are asserted. Required: `pc` and `instruction` are unchanged for 3 cycles and no branch is taken.
- **Wrap-around.**
  - `pc` = 8'hFF with a non-branch instruction → `pc` = 8'h00.
  - `pc` = 8'h00 with a taken branch at offset −2 → `pc` = 8'hFF.
  - Loading 256 bytes auto-exits LOAD after the write at address 8'hFF.
- **Simultaneous and ignored events.**
  - `loadstart` and `start` together in IDLE → LOAD.
  - `start` in LOAD → no effect.
  - `loadvalid` and `loaddone` together → the byte is written, then IDLE.
  - `loadstart` in RUN → ignored.
- **Reset mid-RUN.** Stimulus: assert `resetn` = 0 at `pc` = 3, release, then `start`. Required: immediate `pc` = 0, `running` = 0, `instruction` = 0; on re-run the program is fetched from the retained memory.
